// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational ALU between two requesters (for example
//            the execute stage and a multi-cycle multiply/shift sequencer).
//            Requests are arbitrated round-robin over a valid/ready handshake.
//            The granted operands are latched and presented to the ALU for
//            one cycle. The ALU result and flags are captured and returned to
//            the granted requester over a valid/ready response handshake.
//
// Ports    : clk          - single clock, all state updates on rising edge
//            rst          - asynchronous, active-high reset
//            req_valid    - [1:0] per-requester request valid
//            req_ready    - [1:0] one-hot request accept (combinational)
//            req_a/req_b  - operands, requester i at [i*DATA_W +: DATA_W]
//            req_op       - opcodes, requester i at [i*OP_W +: OP_W]
//            resp_valid   - [1:0] one-hot response valid
//            resp_ready   - [1:0] per-requester response accept
//            resp_result  - captured ALU result (qualified by resp_valid)
//            resp_flags   - captured ALU flags  (qualified by resp_valid)
//            alu_a/alu_b  - registered operands to the ALU
//            alu_op       - registered opcode to the ALU
//            alu_result   - ALU result, combinational from alu_a/alu_b/alu_op
//            alu_flags    - ALU flags, combinational
//            busy         - high in any state other than IDLE
//            grant_cnt    - per-requester completed-op counters, 16 bits each
//
// Options  : ALU_ARB_STATS_EN - when defined, grant_cnt[i*16 +: 16] counts
//            completed response handshakes of requester i (wrapping). When
//            undefined, the counters are not built and grant_cnt is 0.
//
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W  = 16,
    parameter int OP_W    = 4,
    parameter int FLAGS_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [2*OP_W-1:0]     req_op,
    // response side
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_result,
    output logic [FLAGS_W-1:0]    resp_flags,
    // ALU side
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OP_W-1:0]       alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [FLAGS_W-1:0]    alu_flags,
    // status
    output logic                  busy,
    output logic [2*16-1:0]       grant_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam int c_CNT_W = 16;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic                r_ptr;        // round-robin priority pointer
    logic                r_gnt;        // requester owning the operation in flight

    logic                w_gnt_idx;    // requester that would win in IDLE
    logic                w_accept;     // a request transfers this cycle
    logic                w_resp_done;  // response handshake completes this cycle

    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [OP_W-1:0]     w_sel_op;

    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_op;
    logic [DATA_W-1:0]   r_resp_result;
    logic [FLAGS_W-1:0]  r_resp_flags;

    // ------------------------------------------------------------------------
    // Arbitration
    // A lone requester wins regardless of the pointer, so a single busy
    // requester can issue back to back. Only on contention does the pointer
    // decide, and it is flipped away from the winner once its response
    // completes, which yields strict alternation under continuous contention.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_idx = r_ptr;
        case (req_valid)
            2'b01:   w_gnt_idx = 1'b0;
            2'b10:   w_gnt_idx = 1'b1;
            default: w_gnt_idx = r_ptr;
        endcase
    end

    assign w_accept    = (r_state == c_ST_IDLE) && (req_valid != 2'b00);
    // Only the granted requester's ready bit can complete the response.
    assign w_resp_done = (r_state == c_ST_RESP) && resp_ready[r_gnt];

    // Operand select for the winning requester.
    assign w_sel_a  = w_gnt_idx ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
    assign w_sel_b  = w_gnt_idx ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
    assign w_sel_op = w_gnt_idx ? req_op[OP_W +: OP_W]    : req_op[0 +: OP_W];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_EXEC;
                end
            end
            // The ALU is combinational, so a single cycle with the latched
            // operands on alu_* is enough to capture its outputs.
            c_ST_EXEC: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (w_resp_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // resp_valid is decoded from the RESP state and the recorded grant, so it
    // rises on the EXEC edge (when the result is captured) and falls on the
    // completing handshake edge.
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        busy       = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    req_ready = {w_gnt_idx, ~w_gnt_idx};
                end
            end
            c_ST_EXEC: begin
                resp_valid = 2'b00;
            end
            c_ST_RESP: begin
                resp_valid = {r_gnt, ~r_gnt};
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant bookkeeping and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
            r_gnt <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt_idx;
            end
            if (w_resp_done) begin
                r_ptr <= ~r_gnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch and result capture
    // alu_* only load on an accepted request and otherwise hold, so the ALU
    // inputs do not toggle while idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
            end
            if (r_state == c_ST_EXEC) begin
                r_resp_result <= alu_result;
                r_resp_flags  <= alu_flags;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign resp_result = r_resp_result;
    assign resp_flags  = r_resp_flags;

    // ------------------------------------------------------------------------
    // Optional per-requester completion counters
    // ------------------------------------------------------------------------
`ifdef ALU_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stats
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_resp_done && (r_gnt == 1'(gi))) begin
                    r_cnt <= r_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};
                end
            end

            assign grant_cnt[gi*c_CNT_W +: c_CNT_W] = r_cnt;
        end
    endgenerate
`else
    assign grant_cnt = '0;
`endif

endmodule
`default_nettype wire
